// File: rtl/chacha_avalon_bridge_pkg.sv
// ---------------------------------------------------------------------------
// chacha_avalon_bridge_pkg
//   Shared types and constants for the Avalon-MM front end of the chacha core.
//   - bridgeState_t : request FSM (plain commands in IDLE, RMW sequence otherwise)
//   - pipeEntry_t   : one slot of the read-return pipeline {valid, tag}
//   - TAG_USER/RMW  : tells a read issued for the Avalon master apart from the
//                     internal read of a read-modify-write
//   - beWidth()     : byte-lane count for a data width (DATA_W/8)
// ---------------------------------------------------------------------------
package chacha_avalon_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_RD   = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } bridgeState_t;

    localparam logic TAG_USER = 1'b0;
    localparam logic TAG_RMW  = 1'b1;

    typedef struct packed {
        logic valid;
        logic tag;
    } pipeEntry_t;

    function automatic int beWidth(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/chacha_avalon_bridge_if.sv
// ---------------------------------------------------------------------------
// chacha_avalon_bridge_if
//   Avalon-MM slave bus between the SoC interconnect and the chacha bridge.
//   Signal names keep the bridge's port naming (i* = into the bridge,
//   o* = out of the bridge).
//   iChipselect, iRead, iWrite  : command qualifiers
//   iAddress     [ADDR_W]       : word address
//   iWrite_data  [DATA_W]       : write data
//   iByteenable  [DATA_W/8]     : write byte lanes
//   oRead_data   [DATA_W]       : read data, valid with oReaddatavalid
//   oReaddatavalid              : one pulse per accepted read
//   oWaitrequest                : command not accepted this cycle
//   oProtocol_err               : sticky iRead&iWrite error flag
//   modport slave  : the bridge side
//   modport master : the interconnect side
// ---------------------------------------------------------------------------
interface chacha_avalon_bridge_if
    import chacha_avalon_bridge_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int BE_W = beWidth(DATA_W);

    logic              iChipselect;
    logic              iRead;
    logic              iWrite;
    logic [ADDR_W-1:0] iAddress;
    logic [DATA_W-1:0] iWrite_data;
    logic [BE_W-1:0]   iByteenable;
    logic [DATA_W-1:0] oRead_data;
    logic              oReaddatavalid;
    logic              oWaitrequest;
    logic              oProtocol_err;

    modport slave (
        input  iChipselect, iRead, iWrite, iAddress, iWrite_data, iByteenable,
        output oRead_data, oReaddatavalid, oWaitrequest, oProtocol_err
    );

    modport master (
        output iChipselect, iRead, iWrite, iAddress, iWrite_data, iByteenable,
        input  oRead_data, oReaddatavalid, oWaitrequest, oProtocol_err
    );

endinterface

// File: rtl/chacha_avalon_bridge_valid_pipe.sv
// ---------------------------------------------------------------------------
// bridge_valid_pipe
//   Shift register of {valid, tag} that tracks core reads until their data
//   is due. An entry pushed in the cycle the core read is on the bus leaves
//   DEPTH cycles later.
//   iClk, iReset  : clock, asynchronous active-high reset
//   iValid, iTag  : entry pushed this cycle
//   oPreValid     : the entry that leaves next cycle is valid; its core data
//                   is on iCore_rdata right now and must be captured
//   oValid, oTag  : entry leaving the pipe this cycle
// ---------------------------------------------------------------------------
module bridge_valid_pipe
    import chacha_avalon_bridge_pkg::*;
#(
    parameter int DEPTH = 1
)
(
    input  logic iClk,
    input  logic iReset,
    input  logic iValid,
    input  logic iTag,
    output logic oPreValid,
    output logic oValid,
    output logic oTag
);

    pipeEntry_t stage [DEPTH];

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            // NOTE: every stage is reset, not just the head, so a read in
            // flight at reset can never surface as a stray valid pulse.
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= '{valid: iValid, tag: iTag};
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    generate
        if (DEPTH == 1) begin : gPreFromInput
            assign oPreValid = iValid;
        end else begin : gPreFromStage
            assign oPreValid = stage[DEPTH-2].valid;
        end
    endgenerate

    assign oValid = stage[DEPTH-1].valid;
    assign oTag   = stage[DEPTH-1].tag;

endmodule

// File: rtl/chacha_avalon_bridge.sv
// ---------------------------------------------------------------------------
// chacha_avalon_bridge
//   Avalon-MM slave front end for the chacha core register port. Commands are
//   registered onto the core port, reads return through a fixed-latency
//   pipeline with readdatavalid, and partial byte-enable writes are turned
//   into a core read-modify-write while waitrequest holds the bus off.
//
//   Ports
//   iClk, iReset   : clock, asynchronous active-high reset
//   avs            : Avalon-MM slave bus (chacha_avalon_bridge_if.slave); its
//                    ADDR_W/DATA_W must match this module's parameters
//   oCore_cs       : core select, one-cycle pulse per core access
//   oCore_we       : core write enable
//   oCore_addr     : core address, holds when oCore_cs=0
//   oCore_wdata    : core write data, holds when oCore_cs=0
//   iCore_rdata    : core read data, CORE_RD_LAT cycles after a read select
//
//   Timing (command accepted in cycle t, L = CORE_RD_LAT)
//   read          : core read t+1, data sampled t+1+L, oReaddatavalid t+2+L
//   full write    : core write t+1
//   empty write   : accepted, no core access
//   partial write : core read t+1 (RMW_RD), wait for its data in RMW_WAIT,
//                   merged core write t+3+L (RMW_WR); oWaitrequest is high
//                   from t+1 through t+3+L. The RMW read never raises
//                   oReaddatavalid; reads accepted earlier still return.
// ---------------------------------------------------------------------------
module chacha_avalon_bridge
    import chacha_avalon_bridge_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int CORE_RD_LAT = 0
)
(
    input  logic                   iClk,
    input  logic                   iReset,
    chacha_avalon_bridge_if.slave  avs,
    output logic                   oCore_cs,
    output logic                   oCore_we,
    output logic [ADDR_W-1:0]      oCore_addr,
    output logic [DATA_W-1:0]      oCore_wdata,
    input  logic [DATA_W-1:0]      iCore_rdata
);

    localparam int BE_W = beWidth(DATA_W);

    // Registered state
    bridgeState_t      state;
    bridgeState_t      stateNext;
    logic              coreCs;
    logic              coreWe;
    logic              coreTag;
    logic [ADDR_W-1:0] coreAddr;
    logic [DATA_W-1:0] coreWdata;
    logic [ADDR_W-1:0] rmwAddr;
    logic [DATA_W-1:0] rmwWdata;
    logic [BE_W-1:0]   rmwBe;
    logic [DATA_W-1:0] rdCapture;
    logic              protocolErr;

    // Next-state values from the FSM process
    logic              csNext;
    logic              weNext;
    logic              tagNext;
    logic [ADDR_W-1:0] addrNext;
    logic [DATA_W-1:0] wdataNext;
    logic              rmwLoad;

    // Read-return pipeline
    logic              pipePreValid;
    logic              pipeValid;
    logic              pipeTag;

    logic              waitRequest;
    logic              isAccept;
    logic              isConflict;
    logic              isRmwReturn;

    // Byte-lane merge: lanes enabled in be take the new word, others keep old.
    function automatic logic [DATA_W-1:0] mergeLanes(
        input logic [DATA_W-1:0] oldWord,
        input logic [DATA_W-1:0] newWord,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = newWord[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    // The bus is held off for the whole RMW sequence; inputs seen while
    // waitrequest is high are neither accepted nor flagged as errors.
    assign waitRequest = (state != IDLE);
    assign isAccept    = avs.iChipselect & (avs.iRead ^ avs.iWrite) & ~waitRequest;
    assign isConflict  = avs.iChipselect & avs.iRead & avs.iWrite & ~waitRequest;
    assign isRmwReturn = pipeValid & (pipeTag == TAG_RMW);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop
            // updates from pre-edge values regardless of statement order.
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and core command
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        stateNext = state;
        csNext    = 1'b0;
        weNext    = 1'b0;
        tagNext   = TAG_USER;
        addrNext  = coreAddr;
        wdataNext = coreWdata;
        rmwLoad   = 1'b0;

        unique case (state)
            IDLE: begin
                if (isAccept) begin
                    if (avs.iRead) begin
                        csNext   = 1'b1;
                        addrNext = avs.iAddress;
                    end else if (&avs.iByteenable) begin
                        csNext    = 1'b1;
                        weNext    = 1'b1;
                        addrNext  = avs.iAddress;
                        wdataNext = avs.iWrite_data;
                    end else if (|avs.iByteenable) begin
                        // Partial write: fetch the current word first.
                        csNext    = 1'b1;
                        addrNext  = avs.iAddress;
                        tagNext   = TAG_RMW;
                        rmwLoad   = 1'b1;
                        stateNext = RMW_RD;
                    end
                end
            end

            RMW_RD: begin
                // The core read is on the bus this cycle.
                stateNext = RMW_WAIT;
            end

            RMW_WAIT: begin
                // Older user reads may drain first; only the RMW-tagged
                // entry carries the word to merge.
                if (isRmwReturn) begin
                    csNext    = 1'b1;
                    weNext    = 1'b1;
                    addrNext  = rmwAddr;
                    wdataNext = mergeLanes(rdCapture, rmwWdata, rmwBe);
                    stateNext = RMW_WR;
                end
            end

            RMW_WR: begin
                // The merged write is on the bus this cycle.
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Core command, RMW holding registers, read capture, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            coreCs      <= 1'b0;
            coreWe      <= 1'b0;
            coreTag     <= TAG_USER;
            coreAddr    <= '0;
            coreWdata   <= '0;
            rmwAddr     <= '0;
            rmwWdata    <= '0;
            rmwBe       <= '0;
            rdCapture   <= '0;
            protocolErr <= 1'b0;
        end else begin
            coreCs    <= csNext;
            coreWe    <= weNext;
            coreTag   <= tagNext;
            coreAddr  <= addrNext;
            coreWdata <= wdataNext;

            if (rmwLoad) begin
                rmwAddr  <= avs.iAddress;
                rmwWdata <= avs.iWrite_data;
                rmwBe    <= avs.iByteenable;
            end

            if (pipePreValid) begin
                rdCapture <= iCore_rdata;
            end

            if (isConflict) begin
                protocolErr <= 1'b1;
            end
        end
    end

    // Every core read, user or RMW, enters the pipe in the cycle it is on
    // the core bus; it leaves CORE_RD_LAT+1 cycles later with its data.
    bridge_valid_pipe #(
        .DEPTH (CORE_RD_LAT + 1)
    ) uValidPipe (
        .iClk      (iClk),
        .iReset    (iReset),
        .iValid    (coreCs & ~coreWe),
        .iTag      (coreTag),
        .oPreValid (pipePreValid),
        .oValid    (pipeValid),
        .oTag      (pipeTag)
    );

    assign avs.oRead_data     = rdCapture;
    assign avs.oReaddatavalid = pipeValid & (pipeTag == TAG_USER);
    assign avs.oWaitrequest   = waitRequest;
    assign avs.oProtocol_err  = protocolErr;

    assign oCore_cs    = coreCs;
    assign oCore_we    = coreWe;
    assign oCore_addr  = coreAddr;
    assign oCore_wdata = coreWdata;

endmodule

// File: tb/tb_chacha_avalon_bridge.sv
// ---------------------------------------------------------------------------
// tb_chacha_avalon_bridge
//   Directed bench for chacha_avalon_bridge. Two instances: dut0 with a
//   same-cycle core (CORE_RD_LAT=0) and dut2 with a two-cycle core. Each core
//   is a 256-word register file. Inputs change on the falling edge, outputs
//   are observed on the falling edge; cyc counts rising edges, so a command
//   driven while cyc==N is accepted in cycle N.
// ---------------------------------------------------------------------------
module tb_chacha_avalon_bridge;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut0: CORE_RD_LAT = 0 ----------------
    chacha_avalon_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
    logic        core0Cs, core0We;
    logic [7:0]  core0Addr;
    logic [31:0] core0Wdata, core0Rdata;
    logic [31:0] mem0 [256];

    chacha_avalon_bridge #(.ADDR_W(8), .DATA_W(32), .CORE_RD_LAT(0)) dut0 (
        .iClk        (clk),
        .iReset      (rst),
        .avs         (bus0),
        .oCore_cs    (core0Cs),
        .oCore_we    (core0We),
        .oCore_addr  (core0Addr),
        .oCore_wdata (core0Wdata),
        .iCore_rdata (core0Rdata)
    );

    always @(posedge clk) if (core0Cs && core0We) mem0[core0Addr] <= core0Wdata;
    assign core0Rdata = mem0[core0Addr];

    // ---------------- dut2: CORE_RD_LAT = 2 ----------------
    chacha_avalon_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus2 ();
    logic        core2Cs, core2We;
    logic [7:0]  core2Addr, core2A1, core2A2;
    logic [31:0] core2Wdata, core2Rdata;
    logic [31:0] mem2 [256];

    chacha_avalon_bridge #(.ADDR_W(8), .DATA_W(32), .CORE_RD_LAT(2)) dut2 (
        .iClk        (clk),
        .iReset      (rst),
        .avs         (bus2),
        .oCore_cs    (core2Cs),
        .oCore_we    (core2We),
        .oCore_addr  (core2Addr),
        .oCore_wdata (core2Wdata),
        .iCore_rdata (core2Rdata)
    );

    always @(posedge clk) begin
        if (core2Cs && core2We) mem2[core2Addr] <= core2Wdata;
        core2A1 <= core2Addr;
        core2A2 <= core2A1;
    end
    assign core2Rdata = mem2[core2A2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] <= 32'h0;
            mem2[i] <= 32'hA000_0000 + 32'(i);
        end
    end

    // ---------------- event logs ----------------
    int          wrCyc[$];
    logic [39:0] wrRec[$];
    int          rdCyc[$];
    int          vCyc[$];
    logic [31:0] vData[$];
    int          v2Cyc[$];
    logic [31:0] v2Data[$];

    always @(negedge clk) begin
        if (core0Cs && core0We) begin
            wrCyc.push_back(cyc);
            wrRec.push_back({core0Addr, core0Wdata});
        end
        if (core0Cs && !core0We) rdCyc.push_back(cyc);
        if (bus0.oReaddatavalid) begin
            vCyc.push_back(cyc);
            vData.push_back(bus0.oRead_data);
        end
        if (bus2.oReaddatavalid) begin
            v2Cyc.push_back(cyc);
            v2Data.push_back(bus2.oRead_data);
        end
    end

    function automatic logic [76:0] dut0Outputs();
        return {bus0.oRead_data, bus0.oReaddatavalid, bus0.oWaitrequest,
                bus0.oProtocol_err, core0Cs, core0We, core0Addr, core0Wdata};
    endfunction

    task automatic clearLogs();
        wrCyc.delete(); wrRec.delete(); rdCyc.delete();
        vCyc.delete(); vData.delete(); v2Cyc.delete(); v2Data.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idleBus0();
        bus0.iChipselect = 1'b0;
        bus0.iRead       = 1'b0;
        bus0.iWrite      = 1'b0;
    endtask

    // Call just after a falling edge; returns on the falling edge of the
    // cycle after acceptance with the bus idle again.
    task automatic issue(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int accCyc);
        bit accepted;
        accepted = 1'b0;
        accCyc   = -1;
        bus0.iChipselect = 1'b1;
        bus0.iRead       = rd;
        bus0.iWrite      = wr;
        bus0.iAddress    = a;
        bus0.iWrite_data = d;
        bus0.iByteenable = be;
        for (int k = 0; k < 16 && !accepted; k++) begin
            if (!bus0.oWaitrequest) begin
                accepted = 1'b1;
                accCyc   = cyc;
            end
            @(negedge clk);
        end
        idleBus0();
        tests++;
        if (!accepted) begin
            failed++;
            $display("FAIL accept_timeout addr=%h: not accepted within 16 cycles", a);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idleBus0();
        bus2.iChipselect = 1'b0; bus2.iRead = 1'b0; bus2.iWrite = 1'b0;
        bus2.iAddress = '0; bus2.iWrite_data = '0; bus2.iByteenable = '0;
        bus0.iAddress = '0; bus0.iWrite_data = '0; bus0.iByteenable = '0;
        waitCycles(3);
        tests++;
        if (dut0Outputs() !== 77'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %h, want 0", dut0Outputs());
        end
        tests++;
        if ({bus2.oReaddatavalid, bus2.oWaitrequest, bus2.oProtocol_err, core2Cs} !== 4'b0) begin
            failed++;
            $display("FAIL reset_outputs_lat2: got %b, want 0000",
                     {bus2.oReaddatavalid, bus2.oWaitrequest, bus2.oProtocol_err, core2Cs});
        end
        rst = 1'b0;
        waitCycles(2);
    endtask

    task automatic test_full_write_read();
        int accW, accR;
        clearLogs();
        issue(1'b0, 1'b1, 8'h04, 32'h1122_3344, 4'hF, accW);
        waitCycles(3);
        issue(1'b1, 1'b0, 8'h04, 32'h0, 4'h0, accR);
        waitCycles(6);
        tests++;
        if (wrCyc.size() != 1 || wrCyc[0] != accW + 1) begin
            failed++;
            $display("FAIL full_write_timing: writes=%0d first=%0d, want 1 at %0d",
                     wrCyc.size(), (wrCyc.size() > 0) ? wrCyc[0] : -1, accW + 1);
        end
        tests++;
        if (wrRec.size() != 1 || wrRec[0] !== {8'h04, 32'h1122_3344}) begin
            failed++;
            $display("FAIL full_write_data: got %h, want 0411223344",
                     (wrRec.size() > 0) ? wrRec[0] : 40'h0);
        end
        tests++;
        if (rdCyc.size() != 1 || rdCyc[0] != accR + 1) begin
            failed++;
            $display("FAIL read_core_timing: reads=%0d first=%0d, want 1 at %0d",
                     rdCyc.size(), (rdCyc.size() > 0) ? rdCyc[0] : -1, accR + 1);
        end
        tests++;
        if (vCyc.size() != 1 || vCyc[0] != accR + 2) begin
            failed++;
            $display("FAIL read_valid_timing: pulses=%0d first=%0d, want 1 at %0d",
                     vCyc.size(), (vCyc.size() > 0) ? vCyc[0] : -1, accR + 2);
        end
        tests++;
        if (vData.size() != 1 || vData[0] !== 32'h1122_3344) begin
            failed++;
            $display("FAIL read_data: got %h, want 11223344", (vData.size() > 0) ? vData[0] : 32'h0);
        end
    endtask

    task automatic test_partial_write();
        int accW, waitCnt;
        clearLogs();
        issue(1'b0, 1'b1, 8'h04, 32'hAABB_CCDD, 4'b0101, accW);
        waitCnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus0.oWaitrequest) waitCnt++;
            @(negedge clk);
        end
        tests++;
        if (waitCnt != 3) begin
            failed++;
            $display("FAIL rmw_waitrequest_cycles: got %0d, want 3", waitCnt);
        end
        tests++;
        if (rdCyc.size() != 1 || rdCyc[0] != accW + 1) begin
            failed++;
            $display("FAIL rmw_core_read: reads=%0d first=%0d, want 1 at %0d",
                     rdCyc.size(), (rdCyc.size() > 0) ? rdCyc[0] : -1, accW + 1);
        end
        tests++;
        if (wrCyc.size() != 1 || wrCyc[0] != accW + 3) begin
            failed++;
            $display("FAIL rmw_write_timing: writes=%0d first=%0d, want 1 at %0d",
                     wrCyc.size(), (wrCyc.size() > 0) ? wrCyc[0] : -1, accW + 3);
        end
        tests++;
        if (wrRec.size() != 1 || wrRec[0] !== {8'h04, 32'h11BB_33DD}) begin
            failed++;
            $display("FAIL rmw_merged_word: got %h, want 0411BB33DD",
                     (wrRec.size() > 0) ? wrRec[0] : 40'h0);
        end
        tests++;
        if (vCyc.size() != 0) begin
            failed++;
            $display("FAIL rmw_no_valid: got %0d pulses, want 0", vCyc.size());
        end
    endtask

    task automatic test_protocol_err();
        int acc;
        clearLogs();
        issue(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, acc);
        tests++;
        if (bus0.oProtocol_err !== 1'b1) begin
            failed++;
            $display("FAIL err_set: got %b, want 1", bus0.oProtocol_err);
        end
        waitCycles(4);
        tests++;
        if (bus0.oProtocol_err !== 1'b1) begin
            failed++;
            $display("FAIL err_sticky: got %b, want 1", bus0.oProtocol_err);
        end
        tests++;
        if (wrCyc.size() + rdCyc.size() + vCyc.size() != 0) begin
            failed++;
            $display("FAIL err_no_access: writes=%0d reads=%0d valids=%0d, want 0",
                     wrCyc.size(), rdCyc.size(), vCyc.size());
        end
        clearLogs();
        issue(1'b0, 1'b1, 8'h08, 32'hCAFE_F00D, 4'hF, acc);
        waitCycles(2);
        issue(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, acc);
        waitCycles(5);
        tests++;
        if (vData.size() != 1 || vData[0] !== 32'hCAFE_F00D) begin
            failed++;
            $display("FAIL err_later_transfer: pulses=%0d data=%h, want 1 with cafef00d",
                     vData.size(), (vData.size() > 0) ? vData[0] : 32'h0);
        end
    endtask

    task automatic test_read_before_rmw();
        int t;
        clearLogs();
        t = cyc;
        bus0.iChipselect = 1'b1;
        bus0.iRead       = 1'b1;
        bus0.iWrite      = 1'b0;
        bus0.iAddress    = 8'h04;
        bus0.iByteenable = 4'h0;
        @(negedge clk);
        bus0.iRead       = 1'b0;
        bus0.iWrite      = 1'b1;
        bus0.iAddress    = 8'h08;
        bus0.iWrite_data = 32'h1234_5678;
        bus0.iByteenable = 4'b1000;
        @(negedge clk);
        idleBus0();
        waitCycles(10);
        tests++;
        if (vCyc.size() != 1 || vCyc[0] != t + 2) begin
            failed++;
            $display("FAIL overlap_valid_timing: pulses=%0d first=%0d, want 1 at %0d",
                     vCyc.size(), (vCyc.size() > 0) ? vCyc[0] : -1, t + 2);
        end
        tests++;
        if (vData.size() != 1 || vData[0] !== 32'h11BB_33DD) begin
            failed++;
            $display("FAIL overlap_read_data: got %h, want 11bb33dd",
                     (vData.size() > 0) ? vData[0] : 32'h0);
        end
        tests++;
        if (rdCyc.size() != 2 || rdCyc[0] != t + 1 || rdCyc[1] != t + 2) begin
            failed++;
            $display("FAIL overlap_core_reads: count=%0d, want 2 at %0d,%0d",
                     rdCyc.size(), t + 1, t + 2);
        end
        tests++;
        if (wrRec.size() != 1 || wrRec[0] !== {8'h08, 32'h12FE_F00D}) begin
            failed++;
            $display("FAIL overlap_rmw_write: got %h, want 0812fef00d",
                     (wrRec.size() > 0) ? wrRec[0] : 40'h0);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int acc;
        issue(1'b0, 1'b1, 8'h0C, 32'h5566_7788, 4'hF, acc);
        waitCycles(3);
        clearLogs();
        issue(1'b0, 1'b1, 8'h0C, 32'h0000_0000, 4'b0001, acc);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (dut0Outputs() !== 77'h0) begin
            failed++;
            $display("FAIL reset_mid_rmw_outputs: got %h, want 0", dut0Outputs());
        end
        rst = 1'b0;
        waitCycles(4);
        tests++;
        if (wrCyc.size() != 0) begin
            failed++;
            $display("FAIL reset_mid_rmw_no_write: got %0d writes, want 0", wrCyc.size());
        end
        issue(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0, acc);
        waitCycles(5);
        tests++;
        if (vData.size() != 1 || vData[0] !== 32'h5566_7788) begin
            failed++;
            $display("FAIL reset_mid_rmw_old_word: pulses=%0d data=%h, want 1 with 55667788",
                     vData.size(), (vData.size() > 0) ? vData[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back_lat2();
        int t0;
        clearLogs();
        t0 = cyc;
        tests++;
        if (bus2.oWaitrequest !== 1'b0) begin
            failed++;
            $display("FAIL lat2_idle_wait: got %b, want 0", bus2.oWaitrequest);
        end
        bus2.iChipselect = 1'b1;
        bus2.iRead       = 1'b1;
        bus2.iWrite      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.iAddress = 8'(i);
            @(negedge clk);
        end
        bus2.iChipselect = 1'b0;
        bus2.iRead       = 1'b0;
        waitCycles(12);
        tests++;
        if (v2Cyc.size() != 4) begin
            failed++;
            $display("FAIL lat2_pulse_count: got %0d, want 4", v2Cyc.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= v2Cyc.size()) begin
                failed++;
                $display("FAIL lat2_entry%0d: missing, want cycle %0d data %h",
                         i, t0 + 4 + i, 32'hA000_0000 + 32'(i));
            end else if (v2Cyc[i] != t0 + 4 + i || v2Data[i] !== 32'hA000_0000 + 32'(i)) begin
                failed++;
                $display("FAIL lat2_entry%0d: cycle %0d data %h, want cycle %0d data %h",
                         i, v2Cyc[i], v2Data[i], t0 + 4 + i, 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_protocol_err();
        test_read_before_rmw();
        test_reset_mid_rmw();
        test_back_to_back_lat2();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
